// File: rtl/motor_duty_scheduler.sv
// Left/right motor duty scheduler: one time-shared saturating adder computes
// base+corr and base-corr per update tick, with a staleness watchdog and enable gate.

module saturating_adder_signed_unsigned #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W:0]   b,
    output logic [W-1:0] sum
);
    logic [W+1:0] full;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        full = {2'b00, a} + {b[W], b};
        if (full[W+1]) begin
            sum = '0;
        end else if (full[W]) begin
            sum = '1;
        end else begin
            sum = full[W-1:0];
        end
    end
endmodule

module motor_duty_scheduler #(
    parameter int UNSIGNED_WIDTH = 8,
    parameter int TIMEOUT_TICKS  = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      update_tick_in,
    input  logic                      enable_in,
    input  logic [UNSIGNED_WIDTH-1:0] base_speed_in,
    input  logic [UNSIGNED_WIDTH:0]   correction_in,
    input  logic                      correction_valid_in,
    output logic                      correction_ready_out,
    output logic [UNSIGNED_WIDTH-1:0] duty_left_out,
    output logic [UNSIGNED_WIDTH-1:0] duty_right_out,
    output logic                      duty_valid_out,
    output logic                      stale_out,
    output logic                      overrun_out
);
    localparam int W  = UNSIGNED_WIDTH;
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT_TICKS);
    localparam logic [W:0]    CORR_MIN     = {1'b1, {W{1'b0}}};
    localparam logic [W:0]    CORR_NEG_SAT = {1'b0, {W{1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC_L, CALC_R, COMMIT} state_t;
    state_t state_q, state_d;

    logic [W:0]    corr_q;
    logic [W:0]    neg_corr;
    logic [W:0]    adder_b;
    logic [W-1:0]  adder_sum;
    logic [W-1:0]  left_q;
    logic [CW-1:0] wd_count_q;
    logic          accepted_q;
    logic          accept;
    logic          start;
    logic          force_zero;

    assign accept     = correction_valid_in && correction_ready_out;
    assign start      = update_tick_in && (state_q == IDLE);
    assign stale_out  = (wd_count_q == TIMEOUT_C);
    assign force_zero = stale_out || !enable_in;

    // -(-2^W) does not fit in W+1 signed bits, so it clamps to the largest positive value.
    assign neg_corr = (corr_q == CORR_MIN) ? CORR_NEG_SAT : (~corr_q + 1'b1);
    assign adder_b  = (state_q == CALC_R) ? neg_corr : corr_q;

    saturating_adder_signed_unsigned #(.W(W)) u_adder (
        .a   (base_speed_in),
        .b   (adder_b),
        .sum (adder_sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (update_tick_in) state_d = CALC_L;
            CALC_L:  state_d = CALC_R;
            CALC_R:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q              <= IDLE;
            correction_ready_out <= 1'b0;
        end else begin
            state_q              <= state_d;
            correction_ready_out <= (state_d == IDLE) || (state_d == COMMIT);
        end
    end

    // A tick with no accept since the previous tick ages the correction.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            corr_q     <= '0;
            wd_count_q <= '0;
            accepted_q <= 1'b0;
        end else begin
            if (accept) begin
                corr_q <= correction_in;
            end
            if (start) begin
                accepted_q <= 1'b0;
                if (accept) begin
                    wd_count_q <= '0;
                end else if (!accepted_q && (wd_count_q != TIMEOUT_C)) begin
                    wd_count_q <= wd_count_q + 1'b1;
                end
            end else if (accept) begin
                accepted_q <= 1'b1;
                wd_count_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            left_q         <= '0;
            duty_left_out  <= '0;
            duty_right_out <= '0;
            duty_valid_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            if (state_q == CALC_L) begin
                left_q <= adder_sum;
            end
            // The right result goes straight to the output so duties land three cycles after the tick.
            if (state_q == CALC_R) begin
                duty_left_out  <= force_zero ? '0 : left_q;
                duty_right_out <= force_zero ? '0 : adder_sum;
            end
            duty_valid_out <= (state_q == CALC_R);
            overrun_out    <= update_tick_in && (state_q != IDLE);
        end
    end
endmodule

// File: tb/tb_motor_duty_scheduler.sv
// Directed bench for motor_duty_scheduler (W=8, TIMEOUT_TICKS=4) with
// hand-computed duties, latency, watchdog, enable, overrun and reset checks.

module tb_motor_duty_scheduler;
    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       enable;
    logic [7:0] base;
    logic [8:0] corr;
    logic       cvalid;
    logic       cready;
    logic [7:0] duty_l;
    logic [7:0] duty_r;
    logic       dvalid;
    logic       stale;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    motor_duty_scheduler #(
        .UNSIGNED_WIDTH (8),
        .TIMEOUT_TICKS  (4)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .update_tick_in       (tick),
        .enable_in            (enable),
        .base_speed_in        (base),
        .correction_in        (corr),
        .correction_valid_in  (cvalid),
        .correction_ready_out (cready),
        .duty_left_out        (duty_l),
        .duty_right_out       (duty_r),
        .duty_valid_out       (dvalid),
        .stale_out            (stale),
        .overrun_out          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [8:0] c);
        corr   = c;
        cvalid = 1'b1;
        step();
        cvalid = 1'b0;
    endtask

    // Tick for one cycle, then expect the valid pulse exactly three cycles later.
    task automatic tick_and_check(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_r,
                                  input logic exp_stale);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check({tag, "_valid_t1"}, dvalid, 0);
        check({tag, "_ready_calc"}, cready, 0);
        step();
        check({tag, "_valid_t2"}, dvalid, 0);
        step();
        check({tag, "_valid_t3"}, dvalid, 1);
        check({tag, "_left"}, duty_l, exp_l);
        check({tag, "_right"}, duty_r, exp_r);
        check({tag, "_stale"}, stale, exp_stale);
        check({tag, "_ready_commit"}, cready, 1);
        step();
        check({tag, "_valid_t4"}, dvalid, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        tick   = 1'b0;
        enable = 1'b1;
        base   = 8'd0;
        corr   = 9'd0;
        cvalid = 1'b0;
        repeat (2) step();
        check("rst_left", duty_l, 0);
        check("rst_right", duty_r, 0);
        check("rst_valid", dvalid, 0);
        check("rst_stale", stale, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ready", cready, 0);
        rst_n = 1'b1;
        step();
        check("ready_after_release", cready, 1);

        // 1: 200+100 saturates high, 200-100 = 100
        base = 8'd200;
        accept(9'd100);
        tick_and_check("t1", 8'd255, 8'd100, 1'b0);

        // 2: 50-100 saturates low, 50+100 = 150
        base = 8'd50;
        accept(9'h19C);
        tick_and_check("t2", 8'd0, 8'd150, 1'b0);

        // 3: corr=-256 -> neg clamps to 255, 50+255 clamps to 255
        accept(9'h100);
        tick_and_check("t3", 8'd0, 8'd255, 1'b0);

        // 4: four ticks with no accept -> stale on the fourth commit
        tick_and_check("t4_a", 8'd0, 8'd255, 1'b0);
        tick_and_check("t4_b", 8'd0, 8'd255, 1'b0);
        tick_and_check("t4_c", 8'd0, 8'd255, 1'b0);
        tick_and_check("t4_d", 8'd0, 8'd0, 1'b1);
        check("t4_stale_held", stale, 1);
        accept(9'd10);
        check("t4_stale_cleared", stale, 0);
        tick_and_check("t4_recover", 8'd60, 8'd40, 1'b0);

        // 5: enable low forces zeros; tick in CALC_R is dropped with an overrun pulse
        enable = 1'b0;
        base   = 8'd120;
        accept(9'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("t5_overrun_idle", overrun, 0);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("t5_valid", dvalid, 1);
        check("t5_left", duty_l, 0);
        check("t5_right", duty_r, 0);
        check("t5_overrun", overrun, 1);
        step();
        check("t5_overrun_gone", overrun, 0);
        check("t5_valid_gone", dvalid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_single_commit", dvalid, 0);
        end
        enable = 1'b1;

        // 6a: accept and tick in the same IDLE cycle uses the new correction
        corr   = 9'd30;
        cvalid = 1'b1;
        tick   = 1'b1;
        step();
        cvalid = 1'b0;
        tick   = 1'b0;
        step();
        step();
        check("t6_valid", dvalid, 1);
        check("t6_left", duty_l, 150);
        check("t6_right", duty_r, 90);
        step();

        // 6b: reset in CALC_L clears outputs, no valid pulse, correction lost
        corr   = 9'd50;
        cvalid = 1'b1;
        tick   = 1'b1;
        step();
        cvalid = 1'b0;
        tick   = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t6_rst_left", duty_l, 0);
        check("t6_rst_right", duty_r, 0);
        check("t6_rst_ready", cready, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_valid", dvalid, 0);
        end
        check("t6_left_held", duty_l, 0);
        check("t6_ready_back", cready, 1);
        tick_and_check("t6_corr_lost", 8'd120, 8'd120, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
